// File: rtl/apb_timer8_pkg.sv
// apb_timer8_pkg: shared constants for the 8-bit APB timer.
// It holds the register offsets, the TCR/TSR bit positions and the
// prescaler divide encoding, plus a helper that maps that encoding to
// the prescaler terminal count.
package apb_timer8_pkg;

  // Register byte offsets
  localparam int TDR_A  = 0;
  localparam int TCR_A  = 1;
  localparam int TSR_A  = 2;
  localparam int TCNT_A = 3;
  localparam int RSV_A  = 4;
  localparam int TMIN_A = 5;
  localparam int TMAX_A = 6;

  // TCR bit indices
  localparam int TCR_LOAD   = 7;
  localparam int TCR_CMP    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 3;
  localparam int TCR_CKS_LO = 2;
  localparam int TCR_DW     = 1;

  // Writable TCR bits; bits 6 and 0 always read 0
  localparam logic [7:0] TCR_MASK = 8'hBE;

  // TSR bit indices
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  // Terminal count (div-1) of the prescaler for a given encoding
  function automatic logic [3:0] cks_limit(input cks_e cks);
    case (cks)
      CKS_DIV2:  cks_limit = 4'd1;
      CKS_DIV4:  cks_limit = 4'd3;
      CKS_DIV8:  cks_limit = 4'd7;
      default:   cks_limit = 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer8_if.sv
// apb_timer8_if: APB bus bundle for the timer slave.
// Signals: psel, penable, pwrite, paddr, pwdata (master -> slave);
//          prdata, pready, pslverr (slave -> master).
interface apb_timer8_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [7:0]            prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer8_prescaler.sv
// timer8_prescaler: divides clk by 2/4/8/16 and emits a one-cycle tick.
// Ports: clk, rst (async, active-high), en (count enable), clr (restart
// from 0), cks (divide select), tick (one-cycle pulse per period).
module timer8_prescaler
  import apb_timer8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  cks_e cks,
  output logic tick
);
  logic [3:0] cnt;
  logic [3:0] lim;

  assign lim  = cks_limit(cks);
  // A restart in the same cycle suppresses the pending tick
  assign tick = en & ~clr & (cnt == lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (!en || clr || cnt == lim) cnt <= '0;
    else                              cnt <= cnt + 4'd1;
  end
endmodule

// File: rtl/apb_timer8.sv
// apb_timer8: 8-bit up/down timer with APB register interface.
// Ports: pclk (clock), preset (async, active-high reset),
//        apb (slave modport: psel/penable/pwrite/paddr/pwdata in,
//             prdata/pready/pslverr out).
// Registers: TDR(0) TCR(1) TSR(2, write-0-to-clear) TCNT(3, RO)
//            reserved(4) TMIN(5) TMAX(6).
module apb_timer8
  import apb_timer8_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic         pclk,
  input  logic         preset,
  apb_timer8_if.slave  apb
);
  logic [7:0] tdr, tcr, tcnt, tmin, tmax;
  logic [1:0] tsr;
  logic [7:0] wdata;
  logic       access, addr_ok, ro_addr, wr_ok;
  logic       tick, psc_en, psc_clr;
  logic       load, cmp, dw;
  logic [7:0] cnt_nxt;
  logic       set_ovf, set_udf;
  logic       unused_wdata;

  assign wdata        = apb.pwdata[7:0];
  assign unused_wdata = ^apb.pwdata[DATA_WIDTH-1:8];

  // APB decode
  assign access  = apb.psel & apb.penable;
  assign addr_ok = apb.paddr <= ADDR_WIDTH'(TMAX_A);
  assign ro_addr = (apb.paddr == ADDR_WIDTH'(TCNT_A)) | (apb.paddr == ADDR_WIDTH'(RSV_A));
  assign apb.pslverr = access & (~addr_ok | (apb.pwrite & ro_addr));
  assign apb.pready  = 1'b1;
  assign wr_ok       = access & apb.pwrite & ~apb.pslverr;

  always_comb begin
    apb.prdata = 8'h00;
    if (apb.psel && !apb.pwrite) begin
      case (apb.paddr)
        ADDR_WIDTH'(TDR_A):  apb.prdata = tdr;
        ADDR_WIDTH'(TCR_A):  apb.prdata = tcr;
        ADDR_WIDTH'(TSR_A):  apb.prdata = {6'b0, tsr};
        ADDR_WIDTH'(TCNT_A): apb.prdata = tcnt;
        ADDR_WIDTH'(TMIN_A): apb.prdata = tmin;
        ADDR_WIDTH'(TMAX_A): apb.prdata = tmax;
        default:             apb.prdata = 8'h00;
      endcase
    end
  end

  assign load = tcr[TCR_LOAD];
  assign cmp  = tcr[TCR_CMP];
  assign dw   = tcr[TCR_DW];

  // Prescaler restarts whenever the divide select actually changes
  assign psc_en  = tcr[TCR_EN] & ~load;
  assign psc_clr = wr_ok & (apb.paddr == ADDR_WIDTH'(TCR_A)) &
                   (wdata[TCR_CKS_HI:TCR_CKS_LO] != tcr[TCR_CKS_HI:TCR_CKS_LO]);

  timer8_prescaler u_psc (
    .clk  (pclk),
    .rst  (preset),
    .en   (psc_en),
    .clr  (psc_clr),
    .cks  (cks_e'(tcr[TCR_CKS_HI:TCR_CKS_LO])),
    .tick (tick)
  );

  // Counter next-state; compare-mode branch order matters when TMIN > TMAX
  always_comb begin
    cnt_nxt = tcnt;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (load) begin
      cnt_nxt = tdr;
    end else if (tick) begin
      if (!cmp) begin
        if (dw) begin
          cnt_nxt = tcnt - 8'd1;
          set_udf = (tcnt == 8'h00);
        end else begin
          cnt_nxt = tcnt + 8'd1;
          set_ovf = (tcnt == 8'hFF);
        end
      end else if (dw) begin
        if (tcnt > tmax)       cnt_nxt = tmax;
        else if (tcnt <= tmin) begin
          cnt_nxt = tmax;
          set_udf = 1'b1;
        end else               cnt_nxt = tcnt - 8'd1;
      end else begin
        if (tcnt < tmin)       cnt_nxt = tmin;
        else if (tcnt >= tmax) begin
          cnt_nxt = tmin;
          set_ovf = 1'b1;
        end else               cnt_nxt = tcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr  <= 8'h00;
      tcr  <= 8'h00;
      tsr  <= 2'b00;
      tcnt <= 8'h00;
      tmin <= 8'h00;
      tmax <= 8'hFF;
    end else begin
      tcnt <= cnt_nxt;
      // Hardware set is OR'd after the software clear so it wins
      if (wr_ok && apb.paddr == ADDR_WIDTH'(TSR_A))
        tsr <= (tsr & wdata[1:0]) | {set_udf, set_ovf};
      else
        tsr <= tsr | {set_udf, set_ovf};
      if (wr_ok) begin
        case (apb.paddr)
          ADDR_WIDTH'(TDR_A):  tdr  <= wdata;
          ADDR_WIDTH'(TCR_A):  tcr  <= wdata & TCR_MASK;
          ADDR_WIDTH'(TMIN_A): tmin <= wdata;
          ADDR_WIDTH'(TMAX_A): tmax <= wdata;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_apb_timer8.sv
// tb_apb_timer8: directed self-checking bench for apb_timer8.
module tb_apb_timer8;
  import apb_timer8_pkg::*;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  apb_timer8_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  apb_timer8 #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .pclk   (pclk),
    .preset (preset),
    .apb    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Caller is just past a rising edge; commit happens two edges later
  task automatic apb_wr(input logic [11:0] a, input logic [7:0] d, output logic err);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = a; bus.pwdata = {24'h0, d};
    @(posedge pclk); #1 bus.penable = 1'b1;
    @(negedge pclk); err = bus.pslverr;
    @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  // Data is sampled in the access phase, reflecting state after one edge
  task automatic apb_rd(input logic [11:0] a, output logic [7:0] d, output logic err);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    @(posedge pclk); #1 bus.penable = 1'b1;
    @(negedge pclk); d = bus.prdata; err = bus.pslverr;
    @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wr_ok(input string tag, input logic [11:0] a, input logic [7:0] d);
    logic e;
    apb_wr(a, d, e);
    chk({tag, "_err"}, {7'b0, e}, 8'h00);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic e;
    apb_rd(a, d, e);
    chk(tag, d, exp);
    chk({tag, "_err"}, {7'b0, e}, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    logic [7:0] rst_exp [7];

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    rst_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};

    // Reset state
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    chk("rst_pready", {7'b0, bus.pready}, 8'h01);
    chk("rst_pslverr", {7'b0, bus.pslverr}, 8'h00);
    for (int i = 0; i < 7; i++) rd_chk($sformatf("rst_reg%0d", i), 12'(i), rst_exp[i]);

    // Free-running up count, /2, wraps 0xFC -> 0x00 in 4 ticks
    wr_ok("up_tdr", 12'h0, 8'hFC);
    wr_ok("up_load", 12'h1, 8'h80);
    wr_ok("up_tcr", 12'h1, 8'h10);
    repeat (7) @(posedge pclk);
    #1;
    rd_chk("up_tcnt", 12'h3, 8'h00);
    rd_chk("up_tsr", 12'h2, 8'h01);
    wr_ok("up_clr", 12'h2, 8'h00);
    rd_chk("up_tsr_clr", 12'h2, 8'h00);

    // Compare-mode down count, /8, window 0x10..0x20
    wr_ok("cmp_tcr", 12'h1, 8'h3A);
    wr_ok("cmp_tmax1", 12'h6, 8'h40);
    wr_ok("cmp_tmax2", 12'h6, 8'h20);
    wr_ok("cmp_tmin", 12'h5, 8'h10);
    wr_ok("cmp_clr", 12'h2, 8'h00);
    repeat (8 * 22) @(posedge pclk);
    #1;
    rd_chk("cmp_tsr", 12'h2, 8'h02);
    for (int i = 0; i < 4; i++) begin
      apb_rd(12'h3, d, e);
      chk("cmp_range", {7'b0, (d >= 8'h10 && d <= 8'h20)}, 8'h01);
      repeat (5) @(posedge pclk);
      #1;
    end

    // Free-running down count, /16: 0x01 -> 0x00 -> 0xFF
    wr_ok("dn_tdr", 12'h0, 8'h01);
    wr_ok("dn_load", 12'h1, 8'h80);
    wr_ok("dn_clr", 12'h2, 8'h00);
    rd_chk("dn_tsr0", 12'h2, 8'h00);
    wr_ok("dn_tcr", 12'h1, 8'h1E);
    repeat (15) @(posedge pclk);
    #1;
    rd_chk("dn_tcnt16", 12'h3, 8'h00);
    repeat (14) @(posedge pclk);
    #1;
    rd_chk("dn_tcnt32", 12'h3, 8'hFF);
    rd_chk("dn_tsr", 12'h2, 8'h02);

    // Error responses; TCR reserved bits read 0
    apb_rd(12'h7, d, e);
    chk("err_rd7", {7'b0, e}, 8'h01);
    chk("err_rd7_data", d, 8'h00);
    apb_wr(12'h7, 8'h55, e);
    chk("err_wr7", {7'b0, e}, 8'h01);
    wr_ok("err_tcr", 12'h1, 8'hC1);
    rd_chk("err_tcr_rd", 12'h1, 8'h80);
    apb_wr(12'h3, 8'h55, e);
    chk("err_wr_tcnt", {7'b0, e}, 8'h01);
    rd_chk("err_tcnt", 12'h3, 8'h01);
    apb_wr(12'h4, 8'hAA, e);
    chk("err_wr_rsv", {7'b0, e}, 8'h01);
    rd_chk("err_rsv", 12'h4, 8'h00);
    rd_chk("err_tdr", 12'h0, 8'h01);

    // TSR clear committing on the same edge as an underflow tick
    wr_ok("sc_tdr", 12'h0, 8'h02);
    wr_ok("sc_clr0", 12'h2, 8'h00);
    wr_ok("sc_tcr", 12'h1, 8'h12);
    repeat (4) @(posedge pclk);
    #1;
    wr_ok("sc_clr", 12'h2, 8'h00);
    rd_chk("sc_tsr", 12'h2, 8'h02);

    // Asynchronous reset mid-operation
    wr_ok("mr_tmax", 12'h6, 8'h30);
    wr_ok("mr_tmin", 12'h5, 8'h05);
    wr_ok("mr_tdr", 12'h0, 8'h77);
    wr_ok("mr_tcr", 12'h1, 8'h92);
    rd_chk("mr_tcnt_pre", 12'h3, 8'h77);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = 12'h3;
    preset = 1'b1;
    #1;
    chk("mr_async_tcnt", bus.prdata, 8'h00);
    bus.psel = 1'b0;
    for (int i = 0; i < 7; i++) rd_chk($sformatf("mr_reg%0d", i), 12'(i), rst_exp[i]);
    chk("mr_pready", {7'b0, bus.pready}, 8'h01);
    #1 preset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
